// File: rtl/ac_pkg.sv
// Shared types and constants for the multi-zone AC controller.
// Zone state encoding and the sensor-fault code helper.
package ac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAT = 2'd1,
    ST_COOL = 2'd2
  } zone_state_e;

  // An all-ones reading means the sensor is open or shorted.
  function automatic int fault_code(input int tw);
    return (1 << tw) - 1;
  endfunction

endpackage

// File: rtl/ac_zone.sv
// One zone: heat/cool/idle FSM with hysteresis, minimum dwell timer
// and sensor-fault flag.
module ac_zone
  import ac_pkg::*;
#(
  parameter int TW        = 5,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int MIN_DWELL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [TW-1:0] temp,
  output logic          heating,
  output logic          cooling,
  output logic          fault
);

  localparam int CW = $clog2(MIN_DWELL + 1);

  localparam logic [TW-1:0] T_HON  = TW'(HEAT_ON);
  localparam logic [TW-1:0] T_HOFF = TW'(HEAT_OFF);
  localparam logic [TW-1:0] T_CON  = TW'(COOL_ON);
  localparam logic [TW-1:0] T_COFF = TW'(COOL_OFF);
  localparam logic [TW-1:0] T_BAD  = TW'(fault_code(TW));
  localparam logic [CW-1:0] C_MAX  = CW'(MIN_DWELL);

  zone_state_e   state;
  zone_state_e   state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_sat;
  logic          ripe;
  logic          sensor_bad;
  logic          fault_q;

  assign sensor_bad = (temp == T_BAD);

  // Counter value this edge would produce; ripe once that reaches
  // MIN_DWELL, so a state entered at edge k may leave at k+MIN_DWELL.
  assign cnt_sat = (cnt == C_MAX) ? cnt : cnt + 1'b1;
  assign ripe    = (cnt_sat == C_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= C_MAX;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= sensor_bad;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable || sensor_bad) begin
      state_nxt = ST_IDLE;
    end else if (ripe) begin
      unique case (state)
        ST_IDLE: begin
          if (temp <= T_HON) begin
            state_nxt = ST_HEAT;
          end else if (temp >= T_CON) begin
            state_nxt = ST_COOL;
          end
        end
        ST_HEAT: begin
          if (temp >= T_HOFF) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_COOL: begin
          if (temp <= T_COFF) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    heating = (state == ST_HEAT);
    cooling = (state == ST_COOL);
    fault   = fault_q;
  end

endmodule

// File: rtl/ac_zone_ctrl.sv
// Multi-zone AC controller: one independent ac_zone per zone,
// slicing the flattened temperature bus.
module ac_zone_ctrl
  import ac_pkg::*;
#(
  parameter int ZONES     = 2,
  parameter int TW        = 5,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int MIN_DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [ZONES*TW-1:0] temperature,
  output logic [ZONES-1:0]    heating,
  output logic [ZONES-1:0]    cooling,
  output logic [ZONES-1:0]    fault
);

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    ac_zone #(
      .TW        (TW),
      .HEAT_ON   (HEAT_ON),
      .HEAT_OFF  (HEAT_OFF),
      .COOL_ON   (COOL_ON),
      .COOL_OFF  (COOL_OFF),
      .MIN_DWELL (MIN_DWELL)
    ) u_zone (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .temp    (temperature[z*TW +: TW]),
      .heating (heating[z]),
      .cooling (cooling[z]),
      .fault   (fault[z])
    );
  end

endmodule

// File: tb/tb_ac_zone_ctrl.sv
// Directed bench for ac_zone_ctrl: two zones, default thresholds,
// MIN_DWELL=4, outputs sampled 1 time unit after each rising edge.
module tb_ac_zone_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [4:0] t0;
  logic [4:0] t1;
  logic [9:0] temperature;
  logic [1:0] heating;
  logic [1:0] cooling;
  logic [1:0] fault;

  int total  = 0;
  int passed = 0;

  assign temperature = {t1, t0};

  always #5 clk = ~clk;

  ac_zone_ctrl #(
    .ZONES     (2),
    .TW        (5),
    .HEAT_ON   (18),
    .HEAT_OFF  (20),
    .COOL_ON   (22),
    .COOL_OFF  (20),
    .MIN_DWELL (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .temperature (temperature),
    .heating     (heating),
    .cooling     (cooling),
    .fault       (fault)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] got,
                     input logic [1:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, got, exp);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; t0 = 5'd20; t1 = 5'd20;
    step(1);
    chk("rst_heat", heating, 2'b00);
    chk("rst_cool", cooling, 2'b00);
    chk("rst_fault", fault, 2'b00);

    // first edge after reset: zone0 leaves IDLE at once
    rst = 1'b0; enable = 1'b1; t0 = 5'd17; t1 = 5'd21;
    step(1);
    chk("e1_heat", heating, 2'b01);
    chk("e1_cool", cooling, 2'b00);

    // heat-off condition blocked by dwell until k+4
    t0 = 5'd20;
    step(1); chk("dw_k1", heating, 2'b01);
    step(1); chk("dw_k2", heating, 2'b01);
    step(1); chk("dw_k3", heating, 2'b01);
    step(1); chk("dw_k4", heating, 2'b00);

    // zone1 cooling, short dip ignored, exit after dwell
    t1 = 5'd23;
    step(1); chk("c_enter", cooling, 2'b10);
    t1 = 5'd19;
    step(1); chk("c_dip", cooling, 2'b10);
    t1 = 5'd25;
    step(1); chk("c_hot", cooling, 2'b10);
    t1 = 5'd20;
    step(1); chk("c_k3", cooling, 2'b10);
    step(1); chk("c_exit", cooling, 2'b00);
    t1 = 5'd17;
    step(3); chk("i_dwell", heating, 2'b00);
    step(1); chk("i_heat", heating, 2'b10);

    // sensor fault on zone0 while heating
    t0 = 5'd17;
    step(1); chk("f_pre", heating, 2'b11);
    t0 = 5'd31;
    step(1);
    chk("f_heat", heating, 2'b10);
    chk("f_flag", fault, 2'b01);
    t0 = 5'd17;
    step(1);
    chk("f_clr", fault, 2'b00);
    chk("f_idle", heating, 2'b10);
    step(2); chk("f_dw", heating, 2'b10);
    step(1); chk("f_reent", heating, 2'b11);

    // enable drop overrides dwell
    enable = 1'b0;
    step(1);
    chk("en_heat", heating, 2'b00);
    chk("en_cool", cooling, 2'b00);
    enable = 1'b1;
    step(3); chk("en_dw", heating, 2'b00);
    step(1); chk("en_reent", heating, 2'b11);

    // enable low together with fault
    enable = 1'b0; t0 = 5'd31;
    step(1);
    chk("ef_heat", heating, 2'b00);
    chk("ef_fault", fault, 2'b01);
    enable = 1'b1; t0 = 5'd20;
    step(1); chk("ef_clr", fault, 2'b00);

    // reset while zone1 cooling mid-dwell
    t1 = 5'd23;
    step(2); chk("r_pre", cooling, 2'b00);
    step(1); chk("r_cool", cooling, 2'b10);
    step(1); chk("r_mid", cooling, 2'b10);
    rst = 1'b1;
    step(1);
    chk("r_cool0", cooling, 2'b00);
    chk("r_fault0", fault, 2'b00);
    chk("r_heat0", heating, 2'b00);
    rst = 1'b0;
    step(1);
    chk("r_reent", cooling, 2'b10);
    chk("r_heat", heating, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
